// File: rtl/lc3_mem_arbiter.sv
// Two-port round-robin bus controller for the LC-3 memory/IO device block.
// Port 0 is the CPU, port 1 the DMA/display engine; one access is in flight at a time.
module lc3_mem_arbiter #(
  parameter int AW         = 16,
  parameter int DW         = 16,
  parameter int TMO_CYCLES = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    req_valid,
  input  logic [1:0]    req_we,
  input  logic [AW-1:0] req_addr0,
  input  logic [AW-1:0] req_addr1,
  input  logic [DW-1:0] req_wdata0,
  input  logic [DW-1:0] req_wdata1,
  output logic [1:0]    req_ready,
  output logic [1:0]    rsp_valid,
  output logic [DW-1:0] rsp_rdata,
  output logic          rsp_err,
  output logic          busy,
  output logic [DW-1:0] bus_out,
  output logic          bus_oe,
  output logic          ld_mar,
  output logic          ld_mdr,
  output logic          mio_en,
  output logic          r_w,
  output logic          gate_mdr_en,
  input  logic [DW-1:0] mdr_in,
  input  logic          dev_ready
);

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    DATA,
    ACCESS,
    WAIT,
    GATE,
    RESP
  } state_t;

  localparam logic [7:0] TMO_LAST = 8'(TMO_CYCLES - 1);
  localparam logic [7:0] CNT_MAX  = 8'hFF;

  state_t        state_q, state_d;
  logic          last_grant_q, last_grant_d;
  logic          grant_q, grant_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          we_q, we_d;
  logic [7:0]    wait_cnt_q, wait_cnt_d;
  logic          err_q, err_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          sel_port;

  // On a tie the port that did not win last time is chosen.
  always_comb begin
    sel_port = req_valid[1];
    if (req_valid == 2'b11) begin
      sel_port = ~last_grant_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      grant_q      <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      we_q         <= 1'b0;
      wait_cnt_q   <= '0;
      err_q        <= 1'b0;
      rdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      we_q         <= we_d;
      wait_cnt_q   <= wait_cnt_d;
      err_q        <= err_d;
      rdata_q      <= rdata_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    we_d         = we_q;
    wait_cnt_d   = wait_cnt_q;
    err_d        = err_q;
    rdata_d      = rdata_q;
    case (state_q)
      IDLE: begin
        if (|req_valid) begin
          grant_d = sel_port;
          addr_d  = sel_port ? req_addr1 : req_addr0;
          wdata_d = sel_port ? req_wdata1 : req_wdata0;
          we_d    = req_we[sel_port];
          err_d   = 1'b0;
          state_d = ADDR;
        end
      end
      ADDR:   state_d = we_q ? DATA : ACCESS;
      DATA:   state_d = ACCESS;
      ACCESS: begin
        wait_cnt_d = '0;
        state_d    = WAIT;
      end
      WAIT: begin
        if (wait_cnt_q != CNT_MAX) begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
        // dev_ready is stale on the first WAIT cycle, so it only counts from the second.
        if (dev_ready && (wait_cnt_q != 8'd0)) begin
          state_d = we_q ? RESP : GATE;
        end else if (wait_cnt_q == TMO_LAST) begin
          err_d   = 1'b1;
          state_d = RESP;
        end
      end
      GATE: begin
        rdata_d = mdr_in;
        state_d = RESP;
      end
      RESP: begin
        last_grant_d = grant_q;
        err_d        = 1'b0;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready   = 2'b00;
    rsp_valid   = 2'b00;
    rsp_rdata   = '0;
    rsp_err     = 1'b0;
    busy        = (state_q != IDLE);
    bus_out     = '0;
    bus_oe      = 1'b0;
    ld_mar      = 1'b0;
    ld_mdr      = 1'b0;
    mio_en      = 1'b0;
    r_w         = 1'b0;
    gate_mdr_en = 1'b0;
    case (state_q)
      IDLE: begin
        if (!rst && (|req_valid)) begin
          req_ready = sel_port ? 2'b10 : 2'b01;
        end
      end
      ADDR: begin
        ld_mar  = 1'b1;
        bus_oe  = 1'b1;
        bus_out = DW'(addr_q);
      end
      DATA: begin
        ld_mdr  = 1'b1;
        bus_oe  = 1'b1;
        bus_out = wdata_q;
      end
      ACCESS: begin
        mio_en = 1'b1;
        r_w    = we_q;
        ld_mdr = ~we_q;
      end
      GATE: gate_mdr_en = 1'b1;
      RESP: begin
        rsp_valid = grant_q ? 2'b10 : 2'b01;
        rsp_err   = err_q;
        if (!we_q && !err_q) begin
          rsp_rdata = rdata_q;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_lc3_mem_arbiter.sv
// Bench for lc3_mem_arbiter: a behavioural device plus a timeline-based reference
// model that predicts every output on every cycle.
module tb_lc3_mem_arbiter;

  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid, req_we;
  logic [15:0] req_addr0, req_addr1, req_wdata0, req_wdata1;
  logic [1:0]  req_ready, rsp_valid;
  logic [15:0] rsp_rdata, bus_out, mdr_in;
  logic        rsp_err, busy, bus_oe, ld_mar, ld_mdr, mio_en, r_w, gate_mdr_en;
  logic        dev_ready;

  lc3_mem_arbiter #(.AW(16), .DW(16), .TMO_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_we(req_we),
    .req_addr0(req_addr0), .req_addr1(req_addr1),
    .req_wdata0(req_wdata0), .req_wdata1(req_wdata1),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .busy(busy), .bus_out(bus_out), .bus_oe(bus_oe),
    .ld_mar(ld_mar), .ld_mdr(ld_mdr), .mio_en(mio_en), .r_w(r_w),
    .gate_mdr_en(gate_mdr_en), .mdr_in(mdr_in), .dev_ready(dev_ready)
  );

  always #5 clk = ~clk;

  // Device: MAR/MDR/memory; dev_ready drops after ld_mdr or mio_en and rises stall_cfg cycles later.
  logic [15:0] dev_mem [0:65535];
  logic [15:0] dev_mar, dev_mdr;
  int          low_cnt;
  int          stall_cfg;
  bit          mem_init;

  function automatic logic [15:0] fill_val(input logic [15:0] a);
    return (a == 16'h3000) ? 16'hBEEF : (a ^ 16'h5A5A);
  endfunction

  assign mdr_in = dev_mdr;

  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 65536; i++) dev_mem[i] <= fill_val(16'(i));
      mem_init <= 1'b1;
    end
    if (rst) begin
      dev_ready <= 1'b1;
      low_cnt   <= 0;
      dev_mar   <= 16'h0;
      dev_mdr   <= 16'h0;
    end else begin
      if (ld_mar) dev_mar <= bus_out;
      if (ld_mdr) dev_mdr <= bus_oe ? bus_out : dev_mem[dev_mar];
      if (mio_en && r_w) dev_mem[dev_mar] <= dev_mdr;
      if (ld_mdr || mio_en) begin
        low_cnt   <= stall_cfg;
        dev_ready <= 1'b0;
      end else if (low_cnt > 0) begin
        low_cnt   <= low_cnt - 1;
        dev_ready <= (low_cnt == 1);
      end
    end
  end

  // Reference model state: the access in flight and its offset from the accept cycle.
  logic [15:0] ref_mem [0:65535];
  bit          m_active, m_last, m_port, m_we, m_tmo;
  int          m_off, m_resp;
  logic [15:0] m_addr, m_wdata, m_rdata;
  int          acc_port[$];
  int          acc_cycle[$];

  int          cycle, vectors, miscompares;
  int          rsp_cnt, gate_cnt, last_rsp_cycle;
  logic [15:0] last_rsp_rdata;
  logic        last_rsp_err;

  function automatic bit pick_port(input logic [1:0] v, input bit last);
    if (v == 2'b11) return ~last;
    return v[1];
  endfunction

  // Offset of the response cycle from the accept cycle, from the access timeline.
  function automatic int resp_offset(input bit we, input int stall);
    int acc = we ? 3 : 2;
    if (stall >= TMO) return acc + TMO + 1;
    return acc + 1 + stall + (we ? 1 : 2);
  endfunction

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_output(input string tag);
    logic [43:0] exp, obs;
    logic [1:0]  e_ready, e_rv;
    logic [15:0] e_rdata, e_bus;
    logic        e_err, e_busy, e_oe, e_mar, e_mdr, e_mio, e_rw, e_gate;
    int          o, acc;
    e_ready = 2'b00; e_rv = 2'b00; e_rdata = 16'h0; e_bus = 16'h0;
    e_err = 0; e_busy = 0; e_oe = 0; e_mar = 0; e_mdr = 0; e_mio = 0; e_rw = 0; e_gate = 0;
    if (!m_active) begin
      if (req_valid != 2'b00) e_ready = pick_port(req_valid, m_last) ? 2'b10 : 2'b01;
    end else begin
      o      = m_off;
      acc    = m_we ? 3 : 2;
      e_busy = 1'b1;
      e_mar  = (o == 1);
      e_oe   = (o == 1) || (m_we && o == 2);
      e_bus  = (o == 1) ? m_addr : ((m_we && o == 2) ? m_wdata : 16'h0);
      e_mio  = (o == acc);
      e_rw   = m_we && (o == acc);
      e_mdr  = (m_we && o == 2) || (!m_we && o == acc);
      e_gate = !m_we && !m_tmo && (o == m_resp - 1);
      if (o == m_resp) begin
        e_rv    = m_port ? 2'b10 : 2'b01;
        e_err   = m_tmo;
        e_rdata = (!m_we && !m_tmo) ? m_rdata : 16'h0;
      end
    end
    exp = {e_ready, e_rv, e_rdata, e_err, e_busy, e_bus, e_oe, e_mar, e_mdr, e_mio, e_rw, e_gate};
    obs = {req_ready, rsp_valid, rsp_rdata, rsp_err, busy, bus_out, bus_oe, ld_mar, ld_mdr,
           mio_en, r_w, gate_mdr_en};
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s cycle %0d: observed %h expected %h", tag, cycle, obs, exp);
    end
  endtask

  // One clock: check at the falling edge, advance the model at the rising edge.
  task automatic tick(input string tag);
    bit p;
    @(negedge clk);
    if (!rst) begin
      check_output(tag);
      if (rsp_valid != 2'b00) begin
        rsp_cnt++;
        last_rsp_cycle = cycle;
        last_rsp_rdata = rsp_rdata;
        last_rsp_err   = rsp_err;
      end
      if (gate_mdr_en) gate_cnt++;
    end
    @(posedge clk);
    if (rst) begin
      m_active = 1'b0;
      m_last   = 1'b1;
    end else if (!m_active) begin
      if (req_valid != 2'b00) begin
        p       = pick_port(req_valid, m_last);
        m_port  = p;
        m_we    = req_we[p];
        m_addr  = p ? req_addr1 : req_addr0;
        m_wdata = p ? req_wdata1 : req_wdata0;
        m_tmo   = (stall_cfg >= TMO);
        m_resp  = resp_offset(m_we, stall_cfg);
        if (m_we) ref_mem[m_addr] = m_wdata;
        else m_rdata = ref_mem[m_addr];
        m_active = 1'b1;
        m_off    = 1;
        acc_port.push_back(int'(p));
        acc_cycle.push_back(cycle);
      end
    end else if (m_off == m_resp) begin
      m_active = 1'b0;
      m_last   = m_port;
    end else begin
      m_off++;
    end
    cycle++;
    #1;
  endtask

  task automatic apply_stimulus(input logic [1:0] v, input logic [1:0] we,
                                input logic [15:0] a0, input logic [15:0] a1,
                                input logic [15:0] d0, input logic [15:0] d1);
    req_valid  = v;
    req_we     = we;
    req_addr0  = a0;
    req_addr1  = a1;
    req_wdata0 = d0;
    req_wdata1 = d1;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 400 && m_active; i++) tick(tag);
    check_val({tag, "_done"}, 32'(m_active), 32'd0);
  endtask

  int base, rsp_before;

  initial begin
    for (int i = 0; i < 65536; i++) ref_mem[i] = fill_val(16'(i));
    rst       = 1'b1;
    stall_cfg = 1;
    m_last    = 1'b1;
    apply_stimulus(2'b00, 2'b00, 16'h0, 16'h0, 16'h0, 16'h0);
    tick("reset");
    tick("reset");
    rst = 1'b0;
    tick("after_reset");

    // Both ports held from reset: grants alternate with 7-cycle spacing.
    base = acc_port.size();
    apply_stimulus(2'b11, 2'b00, 16'h0100, 16'h0200, 16'h0, 16'h0);
    for (int i = 0; i < 28; i++) tick("rr_hold");
    apply_stimulus(2'b00, 2'b00, 16'h0, 16'h0, 16'h0, 16'h0);
    drain("rr");
    for (int i = 0; i < 4; i++) begin
      check_val("rr_grant", 32'(acc_port[base+i]), 32'(i % 2));
      if (i > 0) check_val("rr_spacing", 32'(acc_cycle[base+i] - acc_cycle[base+i-1]), 32'd7);
    end

    // Port 0 read of 0x3000.
    apply_stimulus(2'b01, 2'b00, 16'h3000, 16'h0, 16'h0, 16'h0);
    tick("rd_accept");
    apply_stimulus(2'b00, 2'b00, 16'h0, 16'h0, 16'h0, 16'h0);
    drain("rd");
    check_val("rd_rdata", 32'(last_rsp_rdata), 32'h0000BEEF);
    check_val("rd_latency", 32'(last_rsp_cycle - acc_cycle[acc_cycle.size()-1]), 32'd6);

    // Port 1 write to FE06: no MDR gate.
    gate_cnt = 0;
    apply_stimulus(2'b10, 2'b10, 16'h0, 16'hFE06, 16'h0, 16'h0041);
    tick("wr_accept");
    apply_stimulus(2'b00, 2'b00, 16'h0, 16'h0, 16'h0, 16'h0);
    drain("wr");
    check_val("wr_latency", 32'(last_rsp_cycle - acc_cycle[acc_cycle.size()-1]), 32'd6);
    check_val("wr_no_gate", 32'(gate_cnt), 32'd0);

    // Device never ready: timeout read, then a normal read.
    stall_cfg = 1000;
    apply_stimulus(2'b01, 2'b00, 16'h1234, 16'h0, 16'h0, 16'h0);
    tick("tmo_accept");
    apply_stimulus(2'b00, 2'b00, 16'h0, 16'h0, 16'h0, 16'h0);
    drain("tmo");
    check_val("tmo_err", 32'(last_rsp_err), 32'd1);
    check_val("tmo_rdata", 32'(last_rsp_rdata), 32'd0);
    check_val("tmo_latency", 32'(last_rsp_cycle - acc_cycle[acc_cycle.size()-1]), 32'd19);
    stall_cfg = 1;
    apply_stimulus(2'b01, 2'b00, 16'h1234, 16'h0, 16'h0, 16'h0);
    tick("post_tmo_accept");
    apply_stimulus(2'b00, 2'b00, 16'h0, 16'h0, 16'h0, 16'h0);
    drain("post_tmo");
    check_val("post_tmo_err", 32'(last_rsp_err), 32'd0);
    check_val("post_tmo_rdata", 32'(last_rsp_rdata), 32'(16'h1234 ^ 16'h5A5A));

    // Reset in the WAIT state of a port 1 write, then a tie goes to port 0.
    stall_cfg = 5;
    apply_stimulus(2'b10, 2'b10, 16'h0, 16'h4000, 16'h0, 16'h7777);
    tick("rstw_accept");
    apply_stimulus(2'b00, 2'b00, 16'h0, 16'h0, 16'h0, 16'h0);
    for (int i = 0; i < 4; i++) tick("rstw_run");
    rsp_before = rsp_cnt;
    rst = 1'b1;
    tick("rstw_reset");
    rst = 1'b0;
    stall_cfg = 1;
    tick("rstw_idle");
    apply_stimulus(2'b11, 2'b00, 16'h4000, 16'h0500, 16'h0, 16'h0);
    tick("rstw_tie");
    apply_stimulus(2'b00, 2'b00, 16'h0, 16'h0, 16'h0, 16'h0);
    check_val("rstw_grant", 32'(acc_port[acc_port.size()-1]), 32'd0);
    drain("rstw");
    check_val("rstw_no_rsp", 32'(rsp_cnt - rsp_before), 32'd1);

    // Port 0 request arrives while port 1 is in ACCESS.
    apply_stimulus(2'b10, 2'b00, 16'h0, 16'h2222, 16'h0, 16'h0);
    tick("late_accept");
    base = acc_cycle.size();
    apply_stimulus(2'b00, 2'b00, 16'h0, 16'h0, 16'h0, 16'h0);
    tick("late_addr");
    apply_stimulus(2'b01, 2'b00, 16'h2224, 16'h0, 16'h0, 16'h0);
    for (int i = 0; i < 20 && acc_cycle.size() == base; i++) tick("late_wait");
    apply_stimulus(2'b00, 2'b00, 16'h0, 16'h0, 16'h0, 16'h0);
    check_val("late_accepted", 32'(acc_cycle.size() - base), 32'd1);
    if (acc_cycle.size() > base)
      check_val("late_gap", 32'(acc_cycle[base] - acc_cycle[base-1]), 32'd7);
    drain("late");

    // Randomized traffic; stall values straddle the timeout boundary.
    for (int n = 0; n < 600; n++) begin
      int r;
      if (!m_active) begin
        r = int'($urandom_range(0, 9));
        if (r <= 5) stall_cfg = 1;
        else if (r == 6) stall_cfg = int'($urandom_range(2, 5));
        else if (r == 7) stall_cfg = TMO - 1;
        else if (r == 8) stall_cfg = TMO;
        else stall_cfg = int'($urandom_range(17, 40));
      end
      apply_stimulus(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                     16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
      tick("random");
    end
    apply_stimulus(2'b00, 2'b00, 16'h0, 16'h0, 16'h0, 16'h0);
    drain("random");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/lc3_mem_arbiter.md
Name: lc3_mem_arbiter

Overview:
- Two-requester bus controller for the LC-3 memory/IO device block. Port 0 is the CPU and port 1 is the DMA/display engine.
- It arbitrates round-robin between the ports and sequences the device control strobes ld_mar, ld_mdr, mio_en, r_w and gate_mdr_en through a fixed state machine.
- It waits on the device ready flag, with a timeout, and returns read data or write completion to the granted requester.
- It sits between the requesters and the shared 16-bit system bus.

Parameters:
- AW, 16, address width (LC-3 address space).
- DW, 16, data width.
- TMO_CYCLES, 16, maximum WAIT cycles before an access is aborted with an error; legal range 2..255.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  2  per-port request valid.
- req_we  in  2  per-port write enable (1 = write, 0 = read).
- req_addr0  in  AW  port 0 address.
- req_addr1  in  AW  port 1 address.
- req_wdata0  in  DW  port 0 write data.
- req_wdata1  in  DW  port 1 write data.
- req_ready  out  2  accept pulse; one-hot, high for one cycle when the request is taken.
- rsp_valid  out  2  one-hot, one-cycle completion pulse to the granted port.
- rsp_rdata  out  DW  read data; valid only while rsp_valid is nonzero.
- rsp_err  out  1  timeout flag; valid only while rsp_valid is nonzero.
- busy  out  1  high in every state except IDLE.
- bus_out  out  DW  value driven onto the system bus.
- bus_oe  out  1  bus drive enable.
- ld_mar  out  1  device MAR load.
- ld_mdr  out  1  device MDR load.
- mio_en  out  1  device memory/IO enable.
- r_w  out  1  device direction (1 = write).
- gate_mdr_en  out  1  device MDR output gate.
- mdr_in  in  DW  device MDR value as seen on the bus.
- dev_ready  in  1  device ready flag; registered in the device, and low the cycle after ld_mdr or a memory enable.

Behaviour:
Reset:
- State goes to IDLE.
- All strobes, req_ready, rsp_valid, rsp_err, bus_oe and busy are 0; bus_out and rsp_rdata are 0.
- last_grant resets to 1, so port 0 wins the first tie.
- Reset asserted mid-access aborts the access: no rsp_valid is issued and the latched request is discarded.

States: IDLE, ADDR, DATA, ACCESS, WAIT, GATE, RESP.
- IDLE:
  - If any req_valid is set, select a port: the only requester, or on a tie the port != last_grant.
  - Pulse req_ready for that port and latch its addr, wdata and we.
  - Go to ADDR.
  - Request inputs are ignored in every other state.
- ADDR: ld_mar=1, bus_oe=1, bus_out=addr. Go to DATA if we, else ACCESS.
- DATA (write only): ld_mdr=1, mio_en=0, bus_oe=1, bus_out=wdata. Go to ACCESS.
- ACCESS:
  - mio_en=1 and r_w=we.
  - ld_mdr=~we, so a read loads the MDR from the device mux.
  - bus_oe=0. Clear wait_cnt. Go to WAIT.
- WAIT:
  - All strobes are 0 and wait_cnt increments each cycle.
  - Exit when dev_ready=1 and wait_cnt!=0; the first WAIT cycle never exits.
  - On exit go to GATE for a read, or RESP for a write.
  - If wait_cnt==TMO_CYCLES-1 without a qualifying dev_ready, set err and go to RESP.
- GATE: gate_mdr_en=1; capture mdr_in into the rdata register. Go to RESP.
- RESP:
  - rsp_valid[g]=1 for exactly one cycle.
  - rsp_rdata=rdata for reads; 0 for writes and timeouts. rsp_err=err.
  - Update last_grant=g, clear err, go to IDLE.

Latency and throughput:
- Measured from the req_ready cycle T, for both reads and writes with a nominal device: rsp_valid occurs at T+6.
  - Read: ADDR T+1, ACCESS T+2, WAIT T+3..T+4, GATE T+5.
  - Write: ADDR T+1, DATA T+2, ACCESS T+3, WAIT T+4..T+5.
- Throughput is at most one access per 7 cycles.
- A new request can be accepted in the IDLE cycle right after RESP.

Other rules:
- Only one access is outstanding at a time.
- A request that is still valid after its req_ready pulse is treated as a new request.
- Address and data are passed through without modification. Mapping of FE00/FE02/FE04/FE06 to registers is done inside the device, not here.
- wait_cnt is 8 bits and saturates; it never wraps.

Test Plan:
1. Port 0 read, addr 0x3000, device returns mdr_in=0xBEEF -> strobes ld_mar@T+1 (bus 0x3000), mio_en+ld_mdr@T+2, gate@T+5; rsp_valid=01, rdata=0xBEEF, err=0 at T+6.
2. Port 1 write, addr 0xFE06, data 0x0041 -> ld_mar@T+1, ld_mdr with bus 0x0041@T+2, mio_en&r_w@T+3; rsp_valid=10 at T+6; gate_mdr_en never asserted.
3. Both ports request from reset, held continuously -> grants alternate 0,1,0,1, each pair of req_ready pulses 7 cycles apart; no port is granted twice in a row.
4. dev_ready held low, TMO_CYCLES=16, read -> 16 WAIT cycles, no GATE, rsp_valid with err=1, rdata=0; the next access completes normally with err=0.
5. rst asserted during WAIT of a write -> next cycle IDLE, all outputs 0, no rsp_valid; a following port 0 request is granted first.
6. Port 0 request arrives while port 1 access is in ACCESS -> req_ready[0] is not asserted until the IDLE cycle after port 1's RESP.
